// File: rtl/anc_pkg.sv
// Shared definitions for the ADC sample sequencer: FSM state encoding and frame length.
package anc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CS_SETUP = 3'd1,
        ST_SHIFT    = 3'd2,
        ST_HOLD     = 3'd3,
        ST_DONE     = 3'd4
    } seq_state_e;

    // Setup + shift + hold + done, in clock cycles.
    function automatic int unsigned frame_len(input int unsigned data_w, input int unsigned sclk_half);
        return 32'd3 + data_w * 32'd2 * sclk_half;
    endfunction

endpackage

// File: rtl/sample_sequencer_if.sv
// ADC-side and downstream signals of the sample sequencer, grouped with sequencer/environment views.
interface sample_sequencer_if #(
    parameter int unsigned DATA_W = 12
);
    logic              Enable;
    logic              Adc_Sdo;
    logic              Adc_Cs_n;
    logic              Adc_Sclk;
    logic [DATA_W-1:0] Sample;
    logic              Sample_Valid;
    logic              S_Out;
    logic              R_Out;
    logic              Overrun;

    modport master (
        input  Enable, Adc_Sdo,
        output Adc_Cs_n, Adc_Sclk, Sample, Sample_Valid, S_Out, R_Out, Overrun
    );

    modport slave (
        output Enable, Adc_Sdo,
        input  Adc_Cs_n, Adc_Sclk, Sample, Sample_Valid, S_Out, R_Out, Overrun
    );
endinterface

// File: rtl/sample_sequencer_sclk_gen.sv
// Half-period divider: Sclk starts low when run rises, toggles every SCLK_HALF cycles,
// rise marks the first high cycle, half_end_c the last cycle of each half-period.
module sclk_gen #(
    parameter int unsigned SCLK_HALF = 2
) (
    input  logic Clk,
    input  logic Rst,
    input  logic run,
    output logic sclk,
    output logic rise,
    output logic half_end_c
);
    localparam int unsigned HW    = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
    localparam logic [HW-1:0] HLAST = HW'(SCLK_HALF - 1);

    logic [HW-1:0] hcnt_q;
    logic          active_q;

    assign half_end_c = active_q && (hcnt_q == HLAST);

    always_ff @(posedge Clk) begin
        if (Rst || !run) begin
            hcnt_q   <= '0;
            sclk     <= 1'b0;
            rise     <= 1'b0;
            active_q <= 1'b0;
        end else if (!active_q) begin
            hcnt_q   <= '0;
            sclk     <= 1'b0;
            rise     <= 1'b0;
            active_q <= 1'b1;
        end else if (half_end_c) begin
            hcnt_q <= '0;
            sclk   <= ~sclk;
            rise   <= ~sclk;
        end else begin
            hcnt_q <= hcnt_q + HW'(1);
            rise   <= 1'b0;
        end
    end
endmodule

// File: rtl/sample_sequencer.sv
// Periodic serial-ADC sampler: period counter launches a chip-select/shift/hold/done frame
// and flags ticks that arrive while a frame is still in flight.
module sample_sequencer
    import anc_pkg::*;
#(
    parameter int unsigned SAMPLE_PERIOD = 64,
    parameter int unsigned DATA_W        = 12,
    parameter int unsigned SCLK_HALF     = 2
) (
    input  logic                Clk,
    input  logic                Rst,
    sample_sequencer_if.master  bus
);
    localparam int unsigned CNT_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_PERIOD - 1);
    localparam logic [BIT_W-1:0] BIT_MSB  = BIT_W'(DATA_W - 1);

    seq_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] shreg_q, sample_q;
    logic              cs_n_q, cs_n_d, s_q, s_d, r_q, r_d, ovr_q;
    logic              tick_c, sclk_run_c, sclk, sclk_rise, half_end_c;

    // Period counter: parked at zero while disabled.
    always_ff @(posedge Clk) begin
        if (Rst || !bus.Enable) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign tick_c = bus.Enable && (cnt_q == CNT_LAST);

    sclk_gen #(.SCLK_HALF(SCLK_HALF)) u_sclk_gen (
        .Clk        (Clk),
        .Rst        (Rst),
        .run        (sclk_run_c),
        .sclk       (sclk),
        .rise       (sclk_rise),
        .half_end_c (half_end_c)
    );

    // Next state; outputs derive from the state being entered so they register in step with it.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        case (state_q)
            ST_IDLE: begin
                if (tick_c) begin
                    state_d = ST_CS_SETUP;
                    bit_d   = BIT_MSB;
                end
            end
            ST_CS_SETUP: state_d = ST_SHIFT;
            ST_SHIFT: begin
                if (sclk && half_end_c) begin
                    if (bit_q == '0) begin
                        state_d = ST_HOLD;
                    end else begin
                        bit_d = bit_q - BIT_W'(1);
                    end
                end
            end
            ST_HOLD: state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        cs_n_d     = !((state_d == ST_CS_SETUP) || (state_d == ST_SHIFT));
        s_d        = (state_d == ST_CS_SETUP);
        r_d        = (state_d == ST_DONE);
        sclk_run_c = (state_d == ST_SHIFT);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= ST_IDLE;
            bit_q    <= '0;
            shreg_q  <= '0;
            sample_q <= '0;
            cs_n_q   <= 1'b1;
            s_q      <= 1'b0;
            r_q      <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            cs_n_q  <= cs_n_d;
            s_q     <= s_d;
            r_q     <= r_d;
            if (tick_c && (state_q != ST_IDLE)) begin
                ovr_q <= 1'b1;
            end
            if (state_q == ST_CS_SETUP) begin
                shreg_q <= '0;
            end else if ((state_q == ST_SHIFT) && sclk_rise) begin
                shreg_q <= {shreg_q[DATA_W-2:0], bus.Adc_Sdo};
            end
            if (state_q == ST_HOLD) begin
                sample_q <= shreg_q;
            end
        end
    end

    assign bus.Adc_Cs_n     = cs_n_q;
    assign bus.Adc_Sclk     = sclk;
    assign bus.Sample       = sample_q;
    assign bus.Sample_Valid = r_q;
    assign bus.S_Out        = s_q;
    assign bus.R_Out        = r_q;
    assign bus.Overrun      = ovr_q;
endmodule

// File: tb/tb_sample_sequencer.sv
// Bench for sample_sequencer: a 64-cycle-period build and a 40-cycle-period build driven
// side by side, with a serial ADC model and a frame-position reference model.
module tb_sample_sequencer;
    localparam int DATA_W    = 12;
    localparam int H         = 2;
    localparam int P0        = 64;
    localparam int P1        = 40;
    localparam int SHIFT_LEN = DATA_W * 2 * H;
    localparam int FRAME     = SHIFT_LEN + 3;
    localparam logic [17:0] RST_VEC = 18'h20000;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    always #5 Clk = ~Clk;

    sample_sequencer_if #(.DATA_W(DATA_W)) if0 ();
    sample_sequencer_if #(.DATA_W(DATA_W)) if1 ();

    sample_sequencer #(.SAMPLE_PERIOD(P0), .DATA_W(DATA_W), .SCLK_HALF(H)) dut0 (
        .Clk(Clk), .Rst(Rst), .bus(if0.master));
    sample_sequencer #(.SAMPLE_PERIOD(P1), .DATA_W(DATA_W), .SCLK_HALF(H)) dut1 (
        .Clk(Clk), .Rst(Rst), .bus(if1.master));

    logic en0 = 1'b0, en1 = 1'b0, sdo0 = 1'b0, sdo1 = 1'b0;
    assign if0.Enable  = en0;
    assign if1.Enable  = en1;
    assign if0.Adc_Sdo = sdo0;
    assign if1.Adc_Sdo = sdo1;

    int total = 0;
    int bad   = 0;

    // Serial ADC: new word per chip-select, MSB first, next bit on each Sclk fall.
    logic [DATA_W-1:0] word0 = '0, word1 = '0, force_val0 = '0;
    logic force0 = 1'b0;
    int idx0 = 0, idx1 = 0;

    always @(negedge if0.Adc_Cs_n) begin
        word0 = force0 ? force_val0 : DATA_W'($urandom);
        idx0  = DATA_W - 1;
        sdo0  = word0[idx0];
    end
    always @(negedge if0.Adc_Sclk) begin
        if (if0.Adc_Cs_n === 1'b0 && idx0 > 0) begin
            idx0 = idx0 - 1;
            sdo0 = word0[idx0];
        end
    end
    always @(negedge if1.Adc_Cs_n) begin
        word1 = DATA_W'($urandom);
        idx1  = DATA_W - 1;
        sdo1  = word1[idx1];
    end
    always @(negedge if1.Adc_Sclk) begin
        if (if1.Adc_Cs_n === 1'b0 && idx1 > 0) begin
            idx1 = idx1 - 1;
            sdo1 = word1[idx1];
        end
    end

    // Reference model: period count plus position within the current frame (-1 = no frame).
    int m_cnt [2] = '{0, 0};
    int m_pos [2] = '{-1, -1};
    logic m_ovr [2] = '{1'b0, 1'b0};
    logic [DATA_W-1:0] m_smp [2] = '{'0, '0};

    function automatic int per_of(input int d);
        return (d == 0) ? P0 : P1;
    endfunction
    function automatic logic en_of(input int d);
        return (d == 0) ? en0 : en1;
    endfunction
    function automatic logic tick_of(input int d);
        return en_of(d) && (m_cnt[d] == per_of(d) - 1);
    endfunction
    function automatic logic [DATA_W-1:0] word_of(input int d);
        return (d == 0) ? word0 : word1;
    endfunction

    always @(posedge Clk) begin
        for (int d = 0; d < 2; d++) begin
            if (Rst) begin
                m_cnt[d] <= 0;
                m_pos[d] <= -1;
                m_ovr[d] <= 1'b0;
                m_smp[d] <= '0;
            end else begin
                m_cnt[d] <= en_of(d) ? (m_cnt[d] + 1) % per_of(d) : 0;
                if (m_pos[d] >= 0) begin
                    if (tick_of(d)) m_ovr[d] <= 1'b1;
                    if (m_pos[d] == FRAME - 2) m_smp[d] <= word_of(d);
                    m_pos[d] <= (m_pos[d] == FRAME - 1) ? -1 : m_pos[d] + 1;
                end else if (tick_of(d)) begin
                    m_pos[d] <= 0;
                end
            end
        end
    end

    // {Cs_n, Sclk, S_Out, R_Out, Sample_Valid, Overrun, Sample}
    function automatic logic [17:0] exp_vec(input int d);
        int p;
        logic cs_n, sclk;
        p    = m_pos[d];
        cs_n = !(p >= 0 && p <= SHIFT_LEN);
        sclk = (p >= 1) && (p <= SHIFT_LEN) && ((((p - 1) / H) % 2) == 1);
        return {cs_n, sclk, p == 0, p == FRAME - 1, p == FRAME - 1, m_ovr[d], m_smp[d]};
    endfunction
    function automatic logic [17:0] obs_vec(input int d);
        if (d == 0)
            return {if0.Adc_Cs_n, if0.Adc_Sclk, if0.S_Out, if0.R_Out, if0.Sample_Valid, if0.Overrun, if0.Sample};
        return {if1.Adc_Cs_n, if1.Adc_Sclk, if1.S_Out, if1.R_Out, if1.Sample_Valid, if1.Overrun, if1.Sample};
    endfunction

    task automatic test_reset();
        Rst = 1'b1;
        en0 = 1'b1;
        en1 = 1'b0;
        force0 = 1'b1;
        force_val0 = 12'hA5C;
        repeat (3) @(negedge Clk);
        for (int d = 0; d < 2; d++) begin
            total++;
            if (obs_vec(d) !== RST_VEC) begin
                bad++;
                $display("FAIL reset_state dut%0d: got %h want %h", d, obs_vec(d), RST_VEC);
            end
        end
    endtask

    task automatic test_first_frame();
        int s_at = -1, cs_at = -1, r_at = -1, rises = 0;
        logic prev = 1'b0;
        logic [DATA_W-1:0] smp = '0;
        Rst = 1'b0;
        for (int k = 1; k <= 130; k++) begin
            @(negedge Clk);
            for (int d = 0; d < 2; d++) begin
                total++;
                if (obs_vec(d) !== exp_vec(d)) begin
                    bad++;
                    $display("FAIL lockstep_first dut%0d k=%0d: got %h want %h", d, k, obs_vec(d), exp_vec(d));
                end
            end
            if (if0.S_Out === 1'b1 && s_at < 0) s_at = k;
            if (s_at >= 0) force0 = 1'b0;
            if (if0.Adc_Cs_n === 1'b0 && cs_at < 0) cs_at = k;
            if (if0.Sample_Valid === 1'b1 && r_at < 0) begin
                r_at = k;
                smp  = if0.Sample;
            end
            if (s_at >= 0 && r_at < 0 && if0.Adc_Sclk === 1'b1 && !prev) rises++;
            prev = if0.Adc_Sclk;
        end
        total += 5;
        if (s_at != P0) begin bad++; $display("FAIL first_s_out cycle: got %0d want %0d", s_at, P0); end
        if (cs_at != P0) begin bad++; $display("FAIL first_cs_low cycle: got %0d want %0d", cs_at, P0); end
        if (r_at != P0 + FRAME - 1) begin bad++; $display("FAIL first_r_out cycle: got %0d want %0d", r_at, P0 + FRAME - 1); end
        if (smp !== 12'hA5C) begin bad++; $display("FAIL first_sample: got %h want a5c", smp); end
        if (rises != DATA_W) begin bad++; $display("FAIL sclk_rises: got %0d want %0d", rises, DATA_W); end
    endtask

    task automatic test_back_to_back();
        int times[$];
        logic ovr_seen = 1'b0;
        for (int k = 1; k <= 4 * P0; k++) begin
            @(negedge Clk);
            for (int d = 0; d < 2; d++) begin
                total++;
                if (obs_vec(d) !== exp_vec(d)) begin
                    bad++;
                    $display("FAIL lockstep_b2b dut%0d k=%0d: got %h want %h", d, k, obs_vec(d), exp_vec(d));
                end
            end
            if (if0.S_Out === 1'b1) times.push_back(k);
            if (if0.Overrun !== 1'b0) ovr_seen = 1'b1;
        end
        total += 2;
        if (times.size() != 4) begin bad++; $display("FAIL b2b_pulse_count: got %0d want 4", times.size()); end
        if (ovr_seen !== 1'b0) begin bad++; $display("FAIL b2b_overrun: got 1 want 0"); end
        for (int i = 1; i < times.size(); i++) begin
            total++;
            if (times[i] - times[i-1] != P0) begin
                bad++;
                $display("FAIL b2b_spacing %0d: got %0d want %0d", i, times[i] - times[i-1], P0);
            end
        end
    endtask

    task automatic test_enable_drop();
        int found = 0, s_cnt = 0, r_cnt = 0, s_at = -1;
        logic [DATA_W-1:0] smp = '0;
        for (int k = 0; k < 80 && found == 0; k++) begin
            @(negedge Clk);
            for (int d = 0; d < 2; d++) begin
                total++;
                if (obs_vec(d) !== exp_vec(d)) begin
                    bad++;
                    $display("FAIL lockstep_endrop dut%0d: got %h want %h", d, obs_vec(d), exp_vec(d));
                end
            end
            if (if0.S_Out === 1'b1) found = 1;
        end
        total++;
        if (found == 0) begin bad++; $display("FAIL endrop_wait_s_out: got timeout want pulse"); end
        repeat (10) @(negedge Clk);
        en0 = 1'b0;
        for (int k = 1; k <= 70; k++) begin
            @(negedge Clk);
            for (int d = 0; d < 2; d++) begin
                total++;
                if (obs_vec(d) !== exp_vec(d)) begin
                    bad++;
                    $display("FAIL lockstep_endrop dut%0d k=%0d: got %h want %h", d, k, obs_vec(d), exp_vec(d));
                end
            end
            if (if0.S_Out === 1'b1) s_cnt++;
            if (if0.R_Out === 1'b1) begin r_cnt++; smp = if0.Sample; end
        end
        total += 3;
        if (r_cnt != 1) begin bad++; $display("FAIL endrop_r_out count: got %0d want 1", r_cnt); end
        if (s_cnt != 0) begin bad++; $display("FAIL endrop_s_out count: got %0d want 0", s_cnt); end
        if (smp !== word0) begin bad++; $display("FAIL endrop_sample: got %h want %h", smp, word0); end
        en0 = 1'b1;
        for (int k = 1; k <= 70; k++) begin
            @(negedge Clk);
            for (int d = 0; d < 2; d++) begin
                total++;
                if (obs_vec(d) !== exp_vec(d)) begin
                    bad++;
                    $display("FAIL lockstep_reen dut%0d k=%0d: got %h want %h", d, k, obs_vec(d), exp_vec(d));
                end
            end
            if (if0.S_Out === 1'b1 && s_at < 0) s_at = k;
        end
        total++;
        if (s_at != P0) begin bad++; $display("FAIL reenable_s_out cycle: got %0d want %0d", s_at, P0); end
    endtask

    task automatic test_overrun();
        int times[$];
        en1 = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge Clk);
            for (int d = 0; d < 2; d++) begin
                total++;
                if (obs_vec(d) !== exp_vec(d)) begin
                    bad++;
                    $display("FAIL lockstep_ovr dut%0d k=%0d: got %h want %h", d, k, obs_vec(d), exp_vec(d));
                end
            end
            if (if1.S_Out === 1'b1) times.push_back(k);
            if (k == 2 * P1 - 1) begin
                total++;
                if (if1.Overrun !== 1'b0) begin bad++; $display("FAIL overrun_early: got %b want 0", if1.Overrun); end
            end
            if (k == 2 * P1) begin
                total++;
                if (if1.Overrun !== 1'b1) begin bad++; $display("FAIL overrun_set: got %b want 1", if1.Overrun); end
            end
        end
        total += 3;
        if (times.size() < 2) begin
            bad++;
            $display("FAIL overrun_s_count: got %0d want >=2", times.size());
        end else begin
            if (times[0] != P1) begin bad++; $display("FAIL overrun_first_s: got %0d want %0d", times[0], P1); end
            if (times[1] != 3 * P1) begin bad++; $display("FAIL overrun_second_s: got %0d want %0d", times[1], 3 * P1); end
        end
        if (if1.Overrun !== 1'b1) begin bad++; $display("FAIL overrun_sticky: got %b want 1", if1.Overrun); end
    endtask

    task automatic test_reset_mid_frame();
        int found = 0, r_cnt = 0;
        for (int k = 0; k < 140 && found == 0; k++) begin
            @(negedge Clk);
            if (if0.S_Out === 1'b1) found = 1;
        end
        total++;
        if (found == 0) begin bad++; $display("FAIL rstmid_wait_s_out: got timeout want pulse"); end
        repeat (5) @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        for (int d = 0; d < 2; d++) begin
            total++;
            if (obs_vec(d) !== RST_VEC) begin
                bad++;
                $display("FAIL rstmid_outputs dut%0d: got %h want %h", d, obs_vec(d), RST_VEC);
            end
        end
        en1 = 1'b0;
        Rst = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge Clk);
            for (int d = 0; d < 2; d++) begin
                total++;
                if (obs_vec(d) !== exp_vec(d)) begin
                    bad++;
                    $display("FAIL lockstep_rstmid dut%0d k=%0d: got %h want %h", d, k, obs_vec(d), exp_vec(d));
                end
            end
            if (if0.R_Out === 1'b1) r_cnt++;
        end
        total++;
        if (r_cnt != 0) begin bad++; $display("FAIL rstmid_r_out: got %0d want 0", r_cnt); end
    endtask

    task automatic test_random();
        for (int k = 1; k <= 3000; k++) begin
            @(negedge Clk);
            for (int d = 0; d < 2; d++) begin
                total++;
                if (obs_vec(d) !== exp_vec(d)) begin
                    bad++;
                    $display("FAIL lockstep_random dut%0d k=%0d: got %h want %h", d, k, obs_vec(d), exp_vec(d));
                end
            end
            Rst = 1'b0;
            if ($urandom_range(39, 0) == 0) en0 = ~en0;
            if ($urandom_range(39, 0) == 0) en1 = ~en1;
            if ($urandom_range(499, 0) == 0) Rst = 1'b1;
        end
        Rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_back_to_back();
        test_enable_drop();
        test_overrun();
        test_reset_mid_frame();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sample_sequencer.md
SAMPLE_SEQUENCER -- requirements
Module: sample_sequencer

Interface
REQ-001 Parameter SAMPLE_PERIOD, default 64: clock cycles per sample tick; SHALL exceed frame length (REQ-012).
REQ-002 Parameter DATA_W, default 12: ADC word width in bits.
REQ-003 Parameter SCLK_HALF, default 2: clock cycles per Adc_Sclk half-period; SHALL be at least 1.
REQ-004 Clk  in  1  single system clock; all logic on rising edge.
REQ-005 Rst  in  1  reset, synchronous, active-high.
REQ-006 Enable  in  1  high permits new sample ticks.
REQ-007 Adc_Sdo  in  1  serial ADC data, MSB first.
REQ-008 Adc_Cs_n  out  1  ADC chip select, active-low.
REQ-009 Adc_Sclk  out  1  ADC serial clock, idle low.
REQ-010 Sample  out  DATA_W  last captured word, unsigned, held until next capture.
REQ-011 Sample_Valid, S_Out, R_Out, Overrun  out  1 each  capture strobe; frame-start pulse (drives downstream RS_FF S); frame-done pulse (drives RS_FF R); sticky missed-tick flag.

Function
REQ-012 Frame = CS_SETUP (1 cycle) + SHIFT (DATA_W*2*SCLK_HALF cycles) + HOLD (1) + DONE (1); default 51 cycles.
REQ-013 Period counter SHALL count 0..SAMPLE_PERIOD-1 and wrap to 0; tick = (count == SAMPLE_PERIOD-1) and Enable.
REQ-014 While Enable low the counter SHALL hold at 0; on Enable rising it counts from 0.
REQ-015 FSM states IDLE, CS_SETUP, SHIFT, HOLD, DONE; all outputs registered.
REQ-016 IDLE -> CS_SETUP on tick; otherwise remain.
REQ-017 CS_SETUP cycle C: Adc_Cs_n low, S_Out high for exactly one cycle, Adc_Sclk low.
REQ-018 SHIFT: per bit, Adc_Sclk low SCLK_HALF cycles then high SCLK_HALF cycles; Adc_Sdo sampled in the first high cycle, shifted in MSB first; bit counter DATA_W-1 down to 0; exit after last high phase.
REQ-019 HOLD: Adc_Cs_n high, Adc_Sclk low, Sample loaded from shift register at end of cycle.
REQ-020 DONE (cycle C+50 at defaults): Sample_Valid and R_Out high for exactly one cycle, Sample already updated; next state IDLE.
REQ-021 S_Out and R_Out SHALL never be high in the same cycle; Sample_Valid coincides with R_Out.
REQ-022 Tick occurring in any state other than IDLE SHALL be dropped (no frame start) and set Overrun; Overrun cleared only by Rst.
REQ-023 Enable deasserted mid-frame: current frame completes normally through DONE; no new frame.
REQ-024 Adc_Cs_n low exactly from CS_SETUP through last SHIFT cycle.

Reset
REQ-025 Rst high at a rising Clk edge SHALL force: state IDLE, counter 0, Adc_Cs_n 1, Adc_Sclk 0, Sample 0, Sample_Valid/S_Out/R_Out/Overrun 0, shift and bit counters 0.
REQ-026 Rst mid-frame SHALL abort the frame with no R_Out or Sample_Valid emitted; downstream RS_FF release is the system's responsibility.

Structure
REQ-027 FSM state encodings and the frame-length constant (function of DATA_W, SCLK_HALF) SHALL live in shared package anc_pkg.
REQ-028 One sub-module natural: sclk_gen (half-period divider producing Sclk level and rising-phase strobe); counter and FSM stay in top.

Verification (SAMPLE_PERIOD=64, DATA_W=12, SCLK_HALF=2)
REQ-029 Rst released, Enable=1 -> S_Out and Adc_Cs_n low in 64th cycle after release; R_Out/Sample_Valid 50 cycles later.
REQ-030 ADC model drives 0xA5C MSB first -> Sample=0xA5C at Sample_Valid; exactly 12 Adc_Sclk rising edges per frame.
REQ-031 Frames back-to-back over 4 periods -> S_Out pulses exactly 64 cycles apart, Overrun stays 0.
REQ-032 Enable dropped 10 cycles after CS_SETUP -> frame completes with valid Sample; no further S_Out; counter at 0.
REQ-033 Force tick during SHIFT (SAMPLE_PERIOD=40 build) -> Overrun=1, no second S_Out until IDLE, Overrun persists until Rst.
REQ-034 Rst asserted during SHIFT -> next cycle all outputs at reset values, no R_Out, Sample=0.
